// File: rtl/fifo_pkg.sv
// Shared constants and parameter checks for the single-clock FIFO.
// Read-mode selectors and threshold sanity function.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic bit fifo_params_ok(
    input int depth,
    input int af,
    input int ae
  );
    bit pow2;
    pow2 = (depth >= 4) &&
           ((depth & (depth - 1)) == 0);
    return pow2 &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read latency 1, no reset, so it maps onto block RAM.
module sdp_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with full-depth use, programmable flags,
// sticky error bits, flush and standard / fall-through read modes.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 512,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 500,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  if (!fifo_params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad
    $error("sync_fifo_fwft: illegal DEPTH or thresholds");
  end

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_re;
  logic [WIDTH-1:0] ram_q;

  assign full   = (count_q == DEPTH_C);
  assign wr_acc = wr_en && !full && !clr;

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (ram_q)
  );

  if (FWFT == FIFO_MODE_STD) begin : g_std
    logic vld_q;
    logic seen_q;

    assign empty  = (count_q == '0);
    assign rd_acc = rd_en && !empty && !clr;
    assign ram_re = rd_acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        seen_q <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) seen_q <= 1'b1;
      end
    end

    // RAM output is unreset; mask it until a word was read.
    assign rd_data  = seen_q ? ram_q : '0;
    assign rd_valid = vld_q;
  end else begin : g_fwft
    logic             mid_q;
    logic             out_vld_q;
    logic [WIDTH-1:0] out_q;
    logic             ram_ne;
    logic             pop;
    logic             out_ld;
    logic             mid_take;

    assign ram_ne   = (wptr_q != rptr_q);
    assign pop      = rd_en && out_vld_q && !clr;
    assign out_ld   = mid_q && (!out_vld_q || pop);
    // mid_q marks the RAM output register as holding the next word.
    assign mid_take = ram_ne && (!mid_q || out_ld) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_q     <= 1'b0;
        out_vld_q <= 1'b0;
        out_q     <= '0;
      end else if (clr) begin
        mid_q     <= 1'b0;
        out_vld_q <= 1'b0;
      end else begin
        mid_q     <= mid_take || (mid_q && !out_ld);
        out_vld_q <= out_ld || (out_vld_q && !pop);
        if (out_ld) out_q <= ram_q;
      end
    end

    assign empty    = !out_vld_q;
    assign rd_acc   = pop;
    assign ram_re   = mid_take;
    assign rd_data  = out_q;
    assign rd_valid = out_vld_q;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (ram_re) rptr_d = rptr_q + 1'b1;
      if (wr_acc && !rd_acc) begin
        count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - 1'b1;
      end
      if (wr_en && full) ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count        = count_q;
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: standard and FWFT instances side by side,
// checked against queue-based models of the FIFO's visible behaviour.
module tb_sync_fifo_fwft;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_empty, f_empty;
  logic       s_full, f_full;
  logic       s_ae, f_ae;
  logic       s_af, f_af;
  logic [3:0] s_count, f_count;
  logic       s_ovf, f_ovf;
  logic       s_udf, f_udf;

  sync_fifo_fwft #(
    .WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_fwft #(
    .WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)
  ) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0] d;
    int         w;
  } fent_t;

  logic [7:0] sq[$];
  fent_t      fq[$];
  bit         m_s_ovf, m_s_udf, m_s_vld;
  bit         m_f_ovf, m_f_udf;
  logic [7:0] m_s_last, m_f_last;
  int         lastpop;
  int         cyc;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // FWFT head is shown once it is two edges past its write edge
  // and no earlier than the edge that popped its predecessor.
  function automatic bit fvis();
    int t;
    if (fq.size() == 0) return 1'b0;
    t = fq[0].w + 2;
    if (lastpop > t) t = lastpop;
    return cyc >= t;
  endfunction

  task automatic model_reset();
    sq.delete();
    fq.delete();
    m_s_ovf = 0; m_s_udf = 0; m_s_vld = 0;
    m_f_ovf = 0; m_f_udf = 0;
    m_s_last = 8'h00; m_f_last = 8'h00;
    lastpop = 0;
  endtask

  task automatic model_edge(input bit c, input bit w,
                            input logic [7:0] d, input bit r);
    bit    fv;
    bit    sfull, ffull;
    fent_t e;
    fv = fvis();
    cyc++;
    if (c) begin
      if (fv) m_f_last = fq[0].d;
      sq.delete();
      fq.delete();
      m_s_ovf = 0; m_s_udf = 0; m_s_vld = 0;
      m_f_ovf = 0; m_f_udf = 0;
      lastpop = 0;
    end else begin
      sfull = (sq.size() == 8);
      m_s_vld = 0;
      if (r && sq.size() == 0) m_s_udf = 1;
      if (w && sfull) m_s_ovf = 1;
      if (r && sq.size() > 0) begin
        m_s_last = sq.pop_front();
        m_s_vld = 1;
      end
      if (w && !sfull) sq.push_back(d);
      ffull = (fq.size() == 8);
      if (r && !fv) m_f_udf = 1;
      if (w && ffull) m_f_ovf = 1;
      if (r && fv) begin
        e = fq.pop_front();
        m_f_last = e.d;
        lastpop = cyc;
      end
      if (w && !ffull) begin
        e.d = d;
        e.w = cyc;
        fq.push_back(e);
      end
    end
  endtask

  task automatic check_all(input string tag);
    int         sn, fn;
    bit         fv;
    logic [7:0] fd;
    sn = sq.size();
    fn = fq.size();
    fv = fvis();
    fd = fv ? fq[0].d : m_f_last;
    chk({tag, ":s_cnt"}, 32'(s_count), 32'(sn));
    chk({tag, ":s_emp"}, 32'(s_empty), 32'(sn == 0));
    chk({tag, ":s_full"}, 32'(s_full), 32'(sn == 8));
    chk({tag, ":s_af"}, 32'(s_af), 32'(sn >= 6));
    chk({tag, ":s_ae"}, 32'(s_ae), 32'(sn <= 1));
    chk({tag, ":s_ovf"}, 32'(s_ovf), 32'(m_s_ovf));
    chk({tag, ":s_udf"}, 32'(s_udf), 32'(m_s_udf));
    chk({tag, ":s_vld"}, 32'(s_rd_valid), 32'(m_s_vld));
    chk({tag, ":s_dat"}, 32'(s_rd_data), 32'(m_s_last));
    chk({tag, ":f_cnt"}, 32'(f_count), 32'(fn));
    chk({tag, ":f_emp"}, 32'(f_empty), 32'(!fv));
    chk({tag, ":f_full"}, 32'(f_full), 32'(fn == 8));
    chk({tag, ":f_af"}, 32'(f_af), 32'(fn >= 6));
    chk({tag, ":f_ae"}, 32'(f_ae), 32'(fn <= 1));
    chk({tag, ":f_ovf"}, 32'(f_ovf), 32'(m_f_ovf));
    chk({tag, ":f_udf"}, 32'(f_udf), 32'(m_f_udf));
    chk({tag, ":f_vld"}, 32'(f_rd_valid), 32'(fv));
    chk({tag, ":f_dat"}, 32'(f_rd_data), 32'(fd));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ":s_cnt"}, 32'(s_count), 32'd0);
    chk({tag, ":s_flags"},
        32'({s_empty, s_ae, s_full, s_af}), 32'b1100);
    chk({tag, ":s_err"}, 32'({s_ovf, s_udf}), 32'd0);
    chk({tag, ":s_out"}, 32'({s_rd_valid, s_rd_data}), 32'd0);
    chk({tag, ":f_cnt"}, 32'(f_count), 32'd0);
    chk({tag, ":f_flags"},
        32'({f_empty, f_ae, f_full, f_af}), 32'b1100);
    chk({tag, ":f_err"}, 32'({f_ovf, f_udf}), 32'd0);
    chk({tag, ":f_out"}, 32'({f_rd_valid, f_rd_data}), 32'd0);
  endtask

  task automatic step(input bit c, input bit w,
                      input logic [7:0] d, input bit r,
                      input string tag);
    clr = c; wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    model_edge(c, w, d, r);
    #1;
    check_all(tag);
    clr = 0; wr_en = 0; rd_en = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    @(negedge clk);
    rst_n = 1;

    // fill, overflow, drain in order
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0, "t1w");
    chk("t1_full", 32'({s_full, f_full}), 32'b11);
    step(0, 1, 8'hEE, 0, "t1ovf");
    chk("t1_ovf", 32'({s_ovf, f_ovf, s_count}), 32'b11_1000);
    for (int i = 0; i < 8; i++) begin
      chk("t1_fhead", 32'(f_rd_data), 32'(8'h10 + i));
      step(0, 0, 8'h00, 1, "t1r");
      chk("t1_sdat", 32'(s_rd_data), 32'(8'h10 + i));
    end
    chk("t1_empty", 32'({s_empty, f_empty}), 32'b11);

    // wrap-around with interleaved single words
    step(1, 0, 8'h00, 0, "t2clr");
    for (int v = 0; v < 20; v++) begin
      step(0, 1, 8'(v), 0, "t2w");
      step(0, 0, 8'h00, 0, "t2n");
      step(0, 0, 8'h00, 0, "t2n");
      chk("t2_fhead", 32'(f_rd_data), 32'(v));
      step(0, 0, 8'h00, 1, "t2r");
      chk("t2_sdat", 32'({s_rd_valid, s_rd_data}), 32'(9'h100 + v));
    end

    // simultaneous read and write at both boundaries
    step(1, 0, 8'h00, 0, "t3clr");
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h80 + i), 0, "t3w");
    step(0, 0, 8'h00, 0, "t3n");
    step(0, 0, 8'h00, 0, "t3n");
    step(0, 1, 8'h99, 1, "t3full");
    chk("t3_full_s", 32'({s_ovf, s_count}), 32'h17);
    chk("t3_full_f", 32'({f_ovf, f_count}), 32'h17);
    for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, "t3r");
    step(0, 1, 8'h42, 1, "t3empty");
    chk("t3_emp_s", 32'({s_udf, s_count}), 32'h11);
    chk("t3_emp_f", 32'({f_udf, f_count}), 32'h11);

    // FWFT latency and gap-free pops
    step(1, 0, 8'h00, 0, "t4clr");
    step(0, 1, 8'hA5, 0, "t4w");
    step(0, 0, 8'h00, 0, "t4n");
    chk("t4_early", 32'(f_rd_valid), 32'd0);
    step(0, 0, 8'h00, 0, "t4n");
    chk("t4_show", 32'({f_rd_valid, f_rd_data}), 32'h1A5);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hB0 + i), 0, "t4w");
    step(0, 0, 8'h00, 0, "t4n");
    step(0, 0, 8'h00, 0, "t4n");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, "t4p");
      chk("t4_b2b", 32'({f_rd_valid, f_rd_data}), 32'(9'h1B0 + i));
    end
    step(0, 0, 8'h00, 1, "t4p");
    chk("t4_last", 32'(f_rd_valid), 32'd0);

    // flush overrides a write
    step(1, 0, 8'h00, 0, "t5clr");
    step(0, 0, 8'h00, 1, "t5udf");
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0, "t5w");
    step(1, 1, 8'h77, 0, "t5flush");
    chk("t5_s", 32'({s_count, s_empty, s_ovf, s_udf}), 32'b0000_100);
    chk("t5_f", 32'({f_count, f_empty, f_ovf, f_udf}), 32'b0000_100);
    step(0, 0, 8'h00, 0, "t5n");
    step(0, 0, 8'h00, 0, "t5n");

    // asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h60 + i), 0, "t6w");
    wr_en = 1; wr_data = 8'h64;
    #2;
    rst_n = 0;
    #1;
    check_reset("t6async");
    wr_en = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 8'h33, 0, "t6w");
    step(0, 0, 8'h00, 0, "t6n");
    step(0, 0, 8'h00, 0, "t6n");
    chk("t6_head", 32'({f_rd_valid, f_rd_data}), 32'h133);
    step(0, 0, 8'h00, 1, "t6r");
    chk("t6_sdat", 32'({s_rd_valid, s_rd_data}), 32'h133);

    // random traffic, write-heavy then read-heavy
    for (int k = 0; k < 400; k++) begin
      bit c, w, r;
      int rp;
      rp = (k < 200) ? 3 : 7;
      c = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < rp);
      step(c, w, 8'($urandom), r, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
